// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight at a time, with a grant-to-response timeout that returns an error.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_resp_valid,
  input  logic                    ifu_resp_ready,
  output logic [DATA_WIDTH-1:0]   ifu_resp_data,
  output logic                    ifu_resp_err,

  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_resp_valid,
  input  logic                    lsu_resp_ready,
  output logic [DATA_WIDTH-1:0]   lsu_resp_data,
  output logic                    lsu_resp_err,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  input  logic                    mem_resp_err
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value during the last cycle allowed before the timeout fires.
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  logic [2:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  drain_q, drain_d;

  logic grant_lsu, grant_ifu;
  logic timeout_hit;
  logic owner_ready;
  logic in_idle;

  // LSU wins ties unless it was the previous owner.
  assign grant_lsu   = lsu_req_valid && (!ifu_req_valid || (last_q == OwnIfu));
  assign grant_ifu   = ifu_req_valid && !grant_lsu;
  assign in_idle     = (state_q == StIdle);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CntLast);
  assign owner_ready = (owner_q == OwnLsu) ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;

    unique case (state_q)
      StIdle: begin
        if (grant_lsu || grant_ifu) begin
          state_d = StReq;
          owner_d = grant_lsu ? OwnLsu : OwnIfu;
          last_d  = grant_lsu ? OwnLsu : OwnIfu;
          cnt_d   = '0;
          drain_d = 1'b0;
          if (grant_lsu) begin
            addr_d  = lsu_req_addr;
            wen_d   = lsu_req_wen;
            wdata_d = lsu_req_wdata;
            wmask_d = lsu_req_wmask;
          end else begin
            addr_d  = ifu_req_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end

      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_req_ready) begin
          state_d = StWait;
        end else if (timeout_hit) begin
          // Memory never took the request, so nothing is left to drain.
          state_d = StResp;
          rdata_d = '0;
          rerr_d  = 1'b1;
          drain_d = 1'b0;
        end
      end

      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp_valid) begin
          state_d = StResp;
          rdata_d = wen_q ? '0 : mem_resp_data;
          rerr_d  = mem_resp_err;
        end else if (timeout_hit) begin
          state_d = StResp;
          rdata_d = '0;
          rerr_d  = 1'b1;
          drain_d = 1'b1;
        end
      end

      StResp: begin
        if (owner_ready) begin
          state_d = drain_q ? StDrain : StIdle;
        end
      end

      StDrain: begin
        // Swallow the late response of the timed-out access.
        if (mem_resp_valid) begin
          state_d = StIdle;
          drain_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      last_q  <= OwnIfu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Grants are combinational on valid; gated by reset so nothing is accepted while held.
  assign ifu_req_ready  = rst && in_idle && grant_ifu;
  assign lsu_req_ready  = rst && in_idle && grant_lsu;

  assign ifu_resp_valid = (state_q == StResp) && (owner_q == OwnIfu);
  assign lsu_resp_valid = (state_q == StResp) && (owner_q == OwnLsu);
  assign ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
  assign ifu_resp_err   = ifu_resp_valid && rerr_q;
  assign lsu_resp_data  = lsu_resp_valid ? rdata_q : '0;
  assign lsu_resp_err   = lsu_resp_valid && rerr_q;

  assign mem_req_valid  = (state_q == StReq);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign mem_resp_ready = (state_q == StWait) || (state_q == StDrain);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant order, latency, stores, timeouts,
// response backpressure and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr = '0;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready = 1'b0;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;

  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr = '0;
  logic        lsu_req_wen = 1'b0;
  logic [31:0] lsu_req_wdata = '0;
  logic [3:0]  lsu_req_wmask = '0;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready = 1'b0;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  // Memory side: either a zero-wait responder or manually driven.
  logic        mem_auto = 1'b0;
  logic        man_req_ready = 1'b0;
  logic        man_resp_valid = 1'b0;
  logic        man_resp_err = 1'b0;
  logic [31:0] mem_rdata = '0;

  assign mem_req_ready  = mem_auto ? 1'b1 : man_req_ready;
  assign mem_resp_valid = mem_auto ? 1'b1 : man_resp_valid;
  assign mem_resp_err   = mem_auto ? 1'b0 : man_resp_err;
  assign mem_resp_data  = mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data (ifu_resp_data),
    .ifu_resp_err  (ifu_resp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_data (lsu_resp_data),
    .lsu_resp_err  (lsu_resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_data (mem_resp_data),
    .mem_resp_err  (mem_resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs any in-flight transaction to completion with no requesters active.
  task automatic finish_txn();
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    mem_auto       = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ifu_req_valid  = 1'($urandom);
      ifu_req_addr   = $urandom;
      ifu_resp_ready = 1'($urandom);
      lsu_req_valid  = 1'($urandom);
      lsu_req_addr   = $urandom;
      lsu_req_wen    = 1'($urandom);
      lsu_req_wdata  = $urandom;
      lsu_req_wmask  = 4'($urandom);
      lsu_resp_ready = 1'($urandom);
      man_req_ready  = 1'($urandom);
      man_resp_valid = 1'($urandom);
      man_resp_err   = 1'($urandom);
      mem_rdata      = $urandom;
      tick();
      outs = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
              mem_req_valid, mem_resp_ready};
      checks++;
      if (outs !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected 000000", outs);
      end
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    man_req_ready = 1'b0; man_resp_valid = 1'b0; man_resp_err = 1'b0;
    rst = 1'b1;
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_2000;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: got lsu=%b ifu=%b expected lsu=1 ifu=0",
               lsu_req_ready, ifu_req_ready);
    end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=00002000",
               mem_req_valid, mem_req_addr);
    end
    finish_txn();
  endtask

  task automatic test_ifu_basic();
    mem_auto = 1'b1; mem_rdata = 32'h0000_0413;
    ifu_resp_ready = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ifu_grant: got %b expected 1", ifu_req_ready);
    end
    tick();
    ifu_req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 ||
        mem_req_wmask !== 4'b0) begin
      errors++;
      $display("FAIL ifu_mem_req: got v=%b a=%h wen=%b m=%b expected v=1 a=80000000 wen=0 m=0000",
               mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
    end
    tick();
    checks++;
    if (ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_early_resp: got %b expected 0", ifu_resp_valid);
    end
    tick();
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_0413 || ifu_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL ifu_resp: got v=%b d=%h e=%b expected v=1 d=00000413 e=0",
               ifu_resp_valid, ifu_resp_data, ifu_resp_err);
    end
    tick();
    checks++;
    if (ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_resp_drop: got %b expected 0", ifu_resp_valid);
    end
  endtask

  task automatic test_alternate();
    int grants = 0;
    int resps = 0;
    int last_c = 0;
    logic exp_lsu;
    mem_auto = 1'b1; mem_rdata = 32'h5555_AAAA;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0100;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0200; lsu_req_wen = 1'b0;
    #1;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      if (ifu_req_ready === 1'b1 && lsu_req_ready === 1'b1) begin
        checks++; errors++;
        $display("FAIL alt_double_grant: got both ready at cycle %0d expected one", c);
      end
      if (ifu_req_ready === 1'b1 || lsu_req_ready === 1'b1) begin
        exp_lsu = (grants % 2 == 0);
        checks++;
        if (lsu_req_ready !== exp_lsu) begin
          errors++;
          $display("FAIL alt_order: grant %0d got lsu=%b expected lsu=%b", grants,
                   lsu_req_ready, exp_lsu);
        end
        if (grants > 0) begin
          checks++;
          if (c - last_c != 4) begin
            errors++;
            $display("FAIL alt_spacing: got %0d cycles expected 4", c - last_c);
          end
        end
        last_c = c;
        grants++;
      end
      if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
        resps++;
        checks++;
        if ((ifu_resp_valid && ifu_resp_data !== 32'h5555_AAAA) ||
            (lsu_resp_valid && lsu_resp_data !== 32'h5555_AAAA)) begin
          errors++;
          $display("FAIL alt_resp_data: got ifu=%h lsu=%h expected 5555aaaa",
                   ifu_resp_data, lsu_resp_data);
        end
      end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) resps++;
      tick();
    end
    checks++;
    if (grants != 8 || resps != 8) begin
      errors++;
      $display("FAIL alt_counts: got grants=%0d resps=%0d expected 8 and 8", grants, resps);
    end
  endtask

  task automatic test_store();
    mem_auto = 1'b1; mem_rdata = 32'h1234_5678;
    lsu_resp_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL store_grant: got %b expected 1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100 || mem_req_wen !== 1'b1 ||
        mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wmask !== 4'b0011) begin
      errors++;
      $display("FAIL store_fields: got v=%b a=%h wen=%b d=%h m=%b expected 1 80000100 1 deadbeef 0011",
               mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
    end
    tick();
    tick();
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h0 || lsu_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: got v=%b d=%h e=%b expected v=1 d=00000000 e=0",
               lsu_resp_valid, lsu_resp_data, lsu_resp_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    mem_auto = 1'b1; mem_rdata = 32'h1111_2222;
    ifu_resp_ready = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant: got %b expected 1", ifu_req_ready);
    end
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0300; lsu_req_wen = 1'b0;
    tick();
    tick();
    mem_rdata = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h1111_2222 ||
          lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b d=%h lrdy=%b mreq=%b expected 1 11112222 0 0",
                 i, ifu_resp_valid, ifu_resp_data, lsu_req_ready, mem_req_valid);
      end
      tick();
    end
    ifu_resp_ready = 1'b1;
    tick();
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got lrdy=%b ifu_v=%b expected lrdy=1 ifu_v=0",
               lsu_req_ready, ifu_resp_valid);
    end
    tick();
    finish_txn();
  endtask

  task automatic test_timeout_req();
    mem_auto = 1'b0; man_req_ready = 1'b0; man_resp_valid = 1'b0;
    lsu_resp_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0400; lsu_req_wen = 1'b0;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tor_grant: got %b expected 1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || lsu_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL tor_req_hold: cycle %0d got mreq=%b lv=%b expected mreq=1 lv=0",
                 i, mem_req_valid, lsu_resp_valid);
      end
      tick();
    end
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b1 || lsu_resp_data !== 32'h0 ||
        mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL tor_resp: got v=%b e=%b d=%h mreq=%b expected 1 1 00000000 0",
               lsu_resp_valid, lsu_resp_err, lsu_resp_data, mem_req_valid);
    end
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0500;
    tick();
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tor_next_grant: got %b expected 1", ifu_req_ready);
    end
    tick();
    finish_txn();
  endtask

  task automatic test_timeout_wait();
    mem_auto = 1'b0; man_req_ready = 1'b1; man_resp_valid = 1'b0;
    lsu_resp_ready = 1'b1; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0600; lsu_req_wen = 1'b0;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tow_grant: got %b expected 1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0;
    tick();
    man_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
        errors++;
        $display("FAIL tow_wait: cycle %0d got lv=%b mrr=%b expected lv=0 mrr=1",
                 i, lsu_resp_valid, mem_resp_ready);
      end
      tick();
    end
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b1 || lsu_resp_data !== 32'h0) begin
      errors++;
      $display("FAIL tow_resp: got v=%b e=%b d=%h expected 1 1 00000000",
               lsu_resp_valid, lsu_resp_err, lsu_resp_data);
    end
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0700;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifu_req_ready !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
        errors++;
        $display("FAIL tow_drain: cycle %0d got irdy=%b lv=%b mrr=%b expected 0 0 1",
                 i, ifu_req_ready, lsu_resp_valid, mem_resp_ready);
      end
      tick();
    end
    man_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    man_resp_valid = 1'b0;
    checks++;
    if (ifu_req_ready !== 1'b1 || lsu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tow_after_drain: got irdy=%b lv=%b expected irdy=1 lv=0",
               ifu_req_ready, lsu_resp_valid);
    end
    tick();
    ifu_req_valid = 1'b0;
    mem_auto = 1'b1; mem_rdata = 32'h0000_600D;
    tick();
    tick();
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_600D || ifu_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL tow_next_resp: got v=%b d=%h e=%b expected 1 0000600d 0",
               ifu_resp_valid, ifu_resp_data, ifu_resp_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0; man_req_ready = 1'b0; man_resp_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0800; lsu_req_wen = 1'b0;
    tick();
    lsu_req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_req: got %b expected 1", mem_req_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got mreq=%b lrdy=%b expected 0 0", mem_req_valid, lsu_req_ready);
    end
    tick();
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0900;
    lsu_req_valid = 1'b1;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_regrant: got lsu=%b ifu=%b expected lsu=1 ifu=0",
               lsu_req_ready, ifu_req_ready);
    end
    tick();
    finish_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ifu_basic();
    test_alternate();
    test_store();
    test_backpressure();
    test_timeout_req();
    test_timeout_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
